// File: rtl/dma_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_arb_pkg
// Purpose  : Shared types and helpers for the DMA read/write arbiters.
// Revision : 1.0 - initial release
// ============================================================================
package dma_arb_pkg;

    localparam int lp_beat_dws = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    // A length of 0 encodes the full 1024-DW transfer.
    function automatic logic [8:0] beats_from_len(input logic [9:0] len);
        logic [10:0] w_sum;
        w_sum = {1'b0, len} + 11'(lp_beat_dws - 1);
        if (len == 10'd0) begin
            return 9'd256;
        end
        return w_sum[10:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_select
// Purpose  : Masked round-robin pick of the lowest eligible requester.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_select #(
    parameter int p_paths = 2
) (
    input  logic [p_paths-1:0] pending,
    input  logic [p_paths-1:0] mask,
    output logic [p_paths-1:0] select,
    output logic               reload
);

    logic [p_paths-1:0] w_eligible;
    logic [p_paths-1:0] w_pool;

    // When every pending path has been served this round, start a new round.
    always_comb begin
        w_eligible = pending & mask;
        reload     = (w_eligible == '0);
        w_pool     = reload ? pending : w_eligible;
        select     = w_pool & (~w_pool + p_paths'(1));
    end

endmodule
`default_nettype wire

// File: rtl/dma_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dma_read_arbiter
// Purpose  : Round-robin share of one host-read DMA engine among p_paths
//            clients; optional stall abort via DMA_READ_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dma_read_arbiter
    import dma_arb_pkg::*;
#(
    parameter int p_paths          = 2,
    parameter int p_timeout_cycles = 65535
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [p_paths*32-1:0]  ar_dma_read_addr,
    input  logic [p_paths*10-1:0]  ar_dma_read_len,
    input  logic [p_paths-1:0]     ar_dma_read_pending,
    output logic [p_paths-1:0]     ar_dma_read_done,
    output logic [p_paths*128-1:0] ar_dma_read_data,
    output logic [p_paths-1:0]     ar_dma_read_data_valid,
    input  logic [p_paths-1:0]     ar_dma_read_data_ready,
    output logic [31:0]            dma_read_addr,
    output logic [9:0]             dma_read_len,
    output logic                   dma_read_pending,
    input  logic                   dma_read_done,
    input  logic [127:0]           dma_read_data,
    input  logic                   dma_read_data_valid,
    output logic                   dma_read_data_ready
`ifdef DMA_READ_ARB_TIMEOUT_EN
    ,
    output logic                   o_timeout
`endif
);

    arb_state_e         r_state, w_state_nxt;
    logic [p_paths-1:0] r_grant, w_grant_nxt;
    logic [p_paths-1:0] r_mask, w_mask_nxt;
    logic [8:0]         r_beats, w_beats_nxt;
    logic [p_paths-1:0] w_sel;
    logic               w_reload;
    logic [9:0]         w_sel_len;
    logic               w_gnt_pending;
    logic               w_done;
    logic               w_hs;
    logic               w_last;
    logic               w_abort;

    rr_priority_select #(
        .p_paths (p_paths)
    ) u_rr (
        .pending (ar_dma_read_pending),
        .mask    (r_mask),
        .select  (w_sel),
        .reload  (w_reload)
    );

    // Grant is one-hot (or zero), so a plain per-path select is a clean mux.
    always_comb begin
        dma_read_addr       = '0;
        dma_read_len        = '0;
        w_gnt_pending       = 1'b0;
        dma_read_data_ready = 1'b0;
        w_sel_len           = '0;
        for (int j = 0; j < p_paths; j++) begin
            if (r_grant[j]) begin
                dma_read_addr       = ar_dma_read_addr[j*32 +: 32];
                dma_read_len        = ar_dma_read_len[j*10 +: 10];
                w_gnt_pending       = ar_dma_read_pending[j];
                dma_read_data_ready = ar_dma_read_data_ready[j];
            end
            if (w_sel[j]) begin
                w_sel_len = ar_dma_read_len[j*10 +: 10];
            end
        end
    end

    always_comb begin
        dma_read_pending       = (r_state == REQ) && w_gnt_pending;
        w_done                 = (r_state == REQ) && dma_read_done;
        ar_dma_read_done       = w_done ? r_grant : '0;
        ar_dma_read_data_valid = dma_read_data_valid ? r_grant : '0;
        ar_dma_read_data       = {p_paths{dma_read_data}};
        w_hs                   = dma_read_data_valid && dma_read_data_ready;
        w_last                 = w_hs && (r_beats == 9'd1);
    end

`ifdef DMA_READ_ARB_TIMEOUT_EN
    logic [31:0] r_timer;

    always_comb begin
        w_abort = (r_state != IDLE) && !(w_done || w_hs)
                  && (r_timer == 32'(p_timeout_cycles - 1));
    end

    assign o_timeout = w_abort;

    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state == IDLE) || w_done || w_hs || w_abort) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(p_timeout_cycles);
    assign w_abort          = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_mask_nxt  = r_mask;
        w_beats_nxt = r_beats;
        if (w_hs && (r_beats != 9'd0)) begin
            w_beats_nxt = r_beats - 9'd1;
        end
        case (r_state)
            IDLE: begin
                if (w_reload) begin
                    w_mask_nxt = '1;
                end
                if (ar_dma_read_pending != '0) begin
                    w_grant_nxt = w_sel;
                    w_mask_nxt  = (w_reload ? {p_paths{1'b1}} : r_mask) & ~w_sel;
                    w_beats_nxt = beats_from_len(w_sel_len);
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                // Beats may race ahead of done; release if they are all in.
                if (w_done) begin
                    if (w_last || (r_beats == 9'd0)) begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (w_last) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_mask  <= '1;
            r_beats <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_mask  <= w_mask_nxt;
            r_beats <= w_beats_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_read_arbiter
// Purpose  : Self-checking bench for dma_read_arbiter (timeout checks only
//            when DMA_READ_ARB_TIMEOUT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_read_arbiter;

    localparam int P  = 2;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [P*32-1:0]  ar_addr;
    logic [P*10-1:0]  ar_len;
    logic [P-1:0]     ar_pend;
    logic [P-1:0]     ar_done;
    logic [P*128-1:0] ar_data;
    logic [P-1:0]     ar_valid;
    logic [P-1:0]     ar_ready;
    logic [31:0]      addr;
    logic [9:0]       len;
    logic             pend;
    logic             done;
    logic [127:0]     data;
    logic             valid;
    logic             ready;
`ifdef DMA_READ_ARB_TIMEOUT_EN
    logic             tmo;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit served [P];
    logic [31:0] m_addr [P];
    logic [9:0]  m_len  [P];

    always #5 clk = ~clk;

    dma_read_arbiter #(
        .p_paths          (P),
        .p_timeout_cycles (TO)
    ) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .ar_dma_read_addr       (ar_addr),
        .ar_dma_read_len        (ar_len),
        .ar_dma_read_pending    (ar_pend),
        .ar_dma_read_done       (ar_done),
        .ar_dma_read_data       (ar_data),
        .ar_dma_read_data_valid (ar_valid),
        .ar_dma_read_data_ready (ar_ready),
        .dma_read_addr          (addr),
        .dma_read_len           (len),
        .dma_read_pending       (pend),
        .dma_read_done          (done),
        .dma_read_data          (data),
        .dma_read_data_valid    (valid),
        .dma_read_data_ready    (ready)
`ifdef DMA_READ_ARB_TIMEOUT_EN
        ,
        .o_timeout              (tmo)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Beats of 4 DWs needed to carry len DWs, len 0 meaning 1024.
    function automatic int exp_beats(input int l);
        int dws;
        dws = (l == 0) ? 1024 : l;
        return (dws + 3) / 4;
    endfunction

    // Round robin: serve the lowest pending path not yet served this round;
    // when none is left, a new round starts.
    function automatic int rr_pick();
        int  pick;
        bit  any;
        pick = -1;
        any  = 1'b0;
        for (int j = 0; j < P; j++) if (ar_pend[j] && !served[j]) any = 1'b1;
        if (!any) for (int j = 0; j < P; j++) served[j] = 1'b0;
        for (int j = P - 1; j >= 0; j--) if (ar_pend[j] && !served[j]) pick = j;
        if (pick >= 0) served[pick] = 1'b1;
        return pick;
    endfunction

    task automatic drive_req(input int p, input logic [31:0] a, input logic [9:0] l);
        m_addr[p]           = a;
        m_len[p]            = l;
        ar_addr[p*32 +: 32] = a;
        ar_len[p*10 +: 10]  = l;
        ar_pend[p]          = 1'b1;
    endtask

    // One full transfer for path p, starting in an IDLE cycle.
    // rdy_mode: 0 ready high/valid random, 1 ready toggling, 2 both random.
    task automatic xfer(input int p, input int rdy_mode, input int pre,
                        input bit with_done, input string tag);
        int n, got, cyc;
        logic v, r;
        logic [127:0] d;
        logic [P-1:0] oh;
        oh  = '0;
        oh[p] = 1'b1;
        n   = exp_beats(int'(m_len[p]));
        got = 0;
        cyc = 0;
        while (pend !== 1'b1 && cyc < 8) begin
            tick();
            valid = 1'b0;
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, 128'(cyc), 128'(1));
        chk({tag, "_addr"}, 128'(addr), 128'(m_addr[p]));
        chk({tag, "_len"}, 128'(len), 128'(m_len[p]));
        for (int k = 0; k < pre; k++) begin
            tick();
            d = rnd128(); data = d; valid = 1'b1; ar_ready = '1;
            #1;
            chk({tag, "_pre_valid"}, 128'(ar_valid), 128'(oh));
            chk({tag, "_pre_data"}, ar_data[p*128 +: 128], d);
            got++;
        end
        tick();
        done = 1'b1; d = rnd128(); data = d; valid = with_done; ar_ready = '1;
        #1;
        chk({tag, "_done"}, 128'(ar_done), 128'(oh));
        if (with_done) got++;
        tick();
        done = 1'b0; ar_pend[p] = 1'b0;
        cyc = 0;
        while (got < n && cyc < 4000) begin
            d = rnd128(); data = d;
            case (rdy_mode)
                1:       begin v = 1'b1; r = (cyc % 2 == 0); end
                2:       begin v = 1'($urandom_range(0, 3) != 0); r = 1'($urandom_range(0, 1)); end
                default: begin v = 1'($urandom_range(0, 3) != 0); r = 1'b1; end
            endcase
            valid = v;
            ar_ready = P'($urandom());
            ar_ready[p] = r;
            #1;
            chk({tag, "_eng_ready"}, 128'(ready), 128'(r));
            chk({tag, "_valid"}, 128'(ar_valid), v ? 128'(oh) : 128'(0));
            chk({tag, "_data"}, ar_data[p*128 +: 128], d);
            chk({tag, "_no_redone"}, 128'(ar_done), 128'(0));
            if (v && r) got++;
            cyc++;
            tick();
        end
        chk({tag, "_beats"}, 128'(got), 128'(n));
        valid = 1'b1; ar_ready = '1;
        #1;
        chk({tag, "_released_ready"}, 128'(ready), 128'(0));
        chk({tag, "_released_valid"}, 128'(ar_valid), 128'(0));
        chk({tag, "_released_pend"}, 128'(pend), 128'(0));
        valid = 1'b0;
    endtask

    // Standalone request after at least one cycle with nothing pending.
    task automatic single(input int p, input logic [31:0] a, input logic [9:0] l,
                          input int mode, input int pre, input bit wd, input string tag);
        int q;
        tick();
        for (int j = 0; j < P; j++) served[j] = 1'b0;
        drive_req(p, a, l);
        q = rr_pick();
        #1;
        xfer(q, mode, pre, wd, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int q;
        int cyc;
        logic [127:0] d;
        rst = 1'b1;
        ar_addr = '0; ar_len = '0; ar_pend = '0; ar_ready = '1;
        done = 1'b1; data = '0; valid = 1'b1;
        for (int j = 0; j < P; j++) begin served[j] = 1'b0; m_addr[j] = '0; m_len[j] = '0; end
        repeat (3) tick();
        #1;
        chk("rst_pend", 128'(pend), 128'(0));
        chk("rst_done", 128'(ar_done), 128'(0));
        chk("rst_valid", 128'(ar_valid), 128'(0));
        chk("rst_ready", 128'(ready), 128'(0));
        chk("rst_addr", 128'(addr), 128'(0));
        chk("rst_len", 128'(len), 128'(0));
`ifdef DMA_READ_ARB_TIMEOUT_EN
        chk("rst_timeout", 128'(tmo), 128'(0));
`endif
        done = 1'b0; valid = 1'b0; ar_ready = '0;
        tick();
        rst = 1'b0;

        // Single request, path 0, 8 DWs -> 2 beats.
        single(0, 32'h0000_1000, 10'd8, 0, 0, 1'b0, "single");

        // Continuous round robin between paths 0 and 1, len 4.
        tick();
        for (int j = 0; j < P; j++) served[j] = 1'b0;
        drive_req(0, 32'hA000_0000, 10'd4);
        drive_req(1, 32'hB000_0000, 10'd4);
        #1;
        for (int t = 0; t < 8; t++) begin
            q = rr_pick();
            xfer(q, 0, 0, 1'b0, "rr");
            if (t < 6) drive_req(q, 32'hC000_0000 + 32'(t * 16 + q), 10'd4);
        end

        // Length edges.
        single(1, 32'h0000_2000, 10'd1, 2, 0, 1'b0, "len1");
        single(1, 32'h0000_3000, 10'd5, 2, 0, 1'b0, "len5");
        single(0, 32'h0000_4000, 10'd0, 2, 0, 1'b0, "len0");

        // Backpressure: 8 beats with path ready toggling.
        single(0, 32'h0000_5000, 10'd32, 1, 0, 1'b0, "bp");

        // Done and final beat together; all beats before done.
        single(1, 32'h0000_6000, 10'd4, 0, 0, 1'b1, "same_cyc");
        single(0, 32'h0000_7000, 10'd4, 0, 1, 1'b0, "pre_done");
        single(1, 32'h0000_8000, 10'd12, 0, 2, 1'b1, "mixed_early");

        // Random traffic with random request arrivals.
        for (int t = 0; t < 12; t++) begin
            for (int j = 0; j < P; j++) begin
                if (!ar_pend[j] && ($urandom_range(0, 1) == 1 || ar_pend == '0))
                    drive_req(j, $urandom(), 10'($urandom_range(1, 64)));
            end
            q = rr_pick();
            xfer(q, $urandom_range(0, 2), 0, 1'b0, "rand");
        end
        while (ar_pend != '0) begin
            q = rr_pick();
            xfer(q, 2, 0, 1'b0, "drain");
        end

        // Reset in the middle of the data phase.
        tick();
        for (int j = 0; j < P; j++) served[j] = 1'b0;
        drive_req(0, 32'h0000_9000, 10'd40);
        #1;
        cyc = 0;
        while (pend !== 1'b1 && cyc < 8) begin tick(); #1; cyc++; end
        chk("mid_rst_grant", 128'(pend), 128'(1));
        tick(); done = 1'b1;
        tick(); done = 1'b0; ar_pend[0] = 1'b0; valid = 1'b1; ar_ready = '1;
        d = rnd128(); data = d;
        #1;
        chk("mid_rst_pre_valid", 128'(ar_valid), 128'(1));
        tick(); rst = 1'b1;
        tick();
        #1;
        chk("mid_rst_valid", 128'(ar_valid), 128'(0));
        chk("mid_rst_ready", 128'(ready), 128'(0));
        chk("mid_rst_pend", 128'(pend), 128'(0));
        rst = 1'b0; valid = 1'b0;
        for (int j = 0; j < P; j++) served[j] = 1'b0;

        // After reset the block serves a fresh request normally.
        single(1, 32'h0000_A000, 10'd16, 0, 0, 1'b0, "post_rst");

`ifdef DMA_READ_ARB_TIMEOUT_EN
        // Stall after done: abort on the 16th silent cycle, other path next.
        tick();
        for (int j = 0; j < P; j++) served[j] = 1'b0;
        drive_req(0, 32'h0000_B000, 10'd8);
        drive_req(1, 32'h0000_C000, 10'd4);
        q = rr_pick();
        #1;
        cyc = 0;
        while (pend !== 1'b1 && cyc < 8) begin tick(); #1; cyc++; end
        chk("tmo_addr", 128'(addr), 128'(m_addr[q]));
        tick(); done = 1'b1;
        #1;
        chk("tmo_done_cycle", 128'(tmo), 128'(0));
        tick(); done = 1'b0; ar_pend[q] = 1'b0; valid = 1'b0; ar_ready = '1;
        for (int k = 1; k <= TO; k++) begin
            #1;
            chk("tmo_pulse", 128'(tmo), 128'(k == TO));
            chk("tmo_no_done", 128'(ar_done), 128'(0));
            tick();
        end
        #1;
        chk("tmo_after_pulse", 128'(tmo), 128'(0));
        q = rr_pick();
        xfer(q, 0, 0, 1'b0, "tmo_next");
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
